// File: rtl/node_net_if.sv
// Node-side network interface: queues 24-bit node messages and serialises them
// as 4-byte packets toward the router, and deserialises 4-byte router packets
// into a receive queue for the node. Packet layout {src[3:0], dest[3:0], data[23:0]},
// transmitted MSB byte first.

// Simple synchronous FIFO; the caller only pushes when not full (or when popping).
module node_net_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Read/write pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array holds data only, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module node_net_if #(
    parameter int NODEID   = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_dest,
    input  logic [23:0] tx_data,
    input  logic        router_free,
    output logic        put,
    output logic [7:0]  payload,
    output logic        node_free,
    input  logic        router_put,
    input  logic [7:0]  router_payload,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [3:0]  rx_src,
    output logic [23:0] rx_data,
    output logic        rx_err,
    output logic        rx_misroute,
    output logic [15:0] tx_count
);
    localparam logic [3:0] ID = 4'(NODEID);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DRAIN} rx_state_t;

    // ---------------- TX side ----------------
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic [27:0] tx_head;

    tx_state_t   tx_state, tx_state_next;
    logic [1:0]  byte_cnt, byte_cnt_next;
    logic [31:0] tx_shift, tx_shift_next;
    logic        put_next;
    logic [7:0]  payload_next;
    logic        count_inc;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    node_net_fifo #(.WIDTH(28), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_push),
        .wdata   ({tx_dest, tx_data}),
        .pop     (tx_pop),
        .rdata   (tx_head),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    // TX next-state: put/payload are computed here and registered, so the byte
    // on payload always matches the SEND cycle it belongs to.
    always_comb begin
        tx_state_next = tx_state;
        byte_cnt_next = byte_cnt;
        tx_shift_next = tx_shift;
        put_next      = 1'b0;
        payload_next  = 8'h00;
        tx_pop        = 1'b0;
        count_inc     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                // router_free is only looked at here; a packet once started always completes
                if (!tx_empty && router_free) begin
                    tx_state_next = TX_SEND;
                    tx_pop        = 1'b1;
                    byte_cnt_next = 2'd0;
                    put_next      = 1'b1;
                    payload_next  = {ID, tx_head[27:24]};
                    tx_shift_next = {tx_head[23:0], 8'h00};
                end
            end
            TX_SEND: begin
                if (byte_cnt == 2'd3) begin
                    tx_state_next = TX_GAP;
                end else begin
                    put_next      = 1'b1;
                    payload_next  = tx_shift[31:24];
                    tx_shift_next = {tx_shift[23:0], 8'h00};
                    byte_cnt_next = byte_cnt + 2'd1;
                end
            end
            TX_GAP: begin
                // one idle put cycle lets the router see the frame end
                tx_state_next = TX_IDLE;
                count_inc     = 1'b1;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX control and output registers; async reset drops put immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            byte_cnt <= 2'd0;
            put      <= 1'b0;
            payload  <= 8'h00;
            tx_count <= 16'd0;
        end else begin
            tx_state <= tx_state_next;
            byte_cnt <= byte_cnt_next;
            put      <= put_next;
            payload  <= payload_next;
            if (count_inc) tx_count <= tx_count + 16'd1;
        end
    end

    // TX shift register holds the remaining bytes of the packet in flight.
    always_ff @(posedge clock) begin
        tx_shift <= tx_shift_next;
    end

    // ---------------- RX side ----------------
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [27:0] rx_head;

    rx_state_t   rx_state, rx_state_next;
    logic [2:0]  rx_cnt, rx_cnt_next;
    logic [31:0] rx_shift, rx_shift_next;
    logic        err_next, misroute_next;

    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_src    = rx_head[27:24];
    assign rx_data   = rx_head[23:0];
    assign node_free = !rx_full && (rx_state == RX_IDLE);

    node_net_fifo #(.WIDTH(28), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (rx_push),
        .wdata   ({rx_shift[31:28], rx_shift[23:0]}),
        .pop     (rx_pop),
        .rdata   (rx_head),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    // RX next-state: a packet is exactly four put cycles framed by put falling.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_shift_next = rx_shift;
        rx_push       = 1'b0;
        err_next      = 1'b0;
        misroute_next = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (router_put) begin
                    rx_shift_next = {24'h000000, router_payload};
                    rx_cnt_next   = 3'd1;
                    rx_state_next = RX_RECV;
                end
            end
            RX_RECV: begin
                if (router_put) begin
                    if (rx_cnt == 3'd4) begin
                        // overlong packet: drop it and wait for put to fall
                        err_next      = 1'b1;
                        rx_state_next = RX_DRAIN;
                    end else begin
                        rx_shift_next = {rx_shift[23:0], router_payload};
                        rx_cnt_next   = rx_cnt + 3'd1;
                    end
                end else begin
                    rx_state_next = RX_IDLE;
                    if (rx_cnt == 3'd4) begin
                        // a pop in the same cycle frees the slot, so a full FIFO is fine then
                        if (!rx_full || rx_pop) begin
                            rx_push       = 1'b1;
                            misroute_next = (rx_shift[27:24] != ID);
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RX_DRAIN: begin
                if (!router_put) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // RX control and status pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= 3'd0;
            rx_err      <= 1'b0;
            rx_misroute <= 1'b0;
        end else begin
            rx_state    <= rx_state_next;
            rx_cnt      <= rx_cnt_next;
            rx_err      <= err_next;
            rx_misroute <= misroute_next;
        end
    end

    // RX shift register assembles incoming bytes, first byte ends up on top.
    always_ff @(posedge clock) begin
        rx_shift <= rx_shift_next;
    end
endmodule
